// File: rtl/alu_shift_issue_pkg.sv
// Shared constants for the shift-ALU issue stage: data width, opcode encodings
// and the legal-opcode test.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_W  = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_SLL = 4'h6;
    localparam logic [OPC_W-1:0] OP_SAR = 4'h7;
    localparam logic [OPC_W-1:0] OP_ROL = 4'h8;
    localparam logic [OPC_W-1:0] OP_ROR = 4'h9;

    function automatic logic is_legal_shift_op(input logic [OPC_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SAR) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_shift_issue_if.sv
// Request/response bundle between the issuer and the shift-ALU issue stage.
interface alu_shift_issue_if
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OPC_W-1:0]  in_opcode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/alu_shift_issue_amt_norm.sv
// Combinational shift-amount normaliser: clamps SLL/SAR amounts at the data
// width, reduces rotate amounts mod 16, and squashes illegal opcodes to NOP.
module alu_shift_amt_norm
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] raw_b,
    output logic [DATA_W-1:0] norm_b_c,
    output logic [OPC_W-1:0]  norm_op_c,
    output logic              err_c
);
    localparam logic [DATA_W-1:0] SHIFT_MAX = DATA_W'(DATA_W);

    always_comb begin
        norm_b_c  = '0;
        norm_op_c = OP_NOP;
        err_c     = !is_legal_shift_op(opcode);
        case (opcode)
            OP_SLL, OP_SAR: begin
                norm_op_c = opcode;
                norm_b_c  = (raw_b >= SHIFT_MAX) ? SHIFT_MAX : raw_b;
            end
            OP_ROL, OP_ROR: begin
                norm_op_c = opcode;
                norm_b_c  = {12'b0, raw_b[3:0]};
            end
            default: begin
                norm_op_c = OP_NOP;
                norm_b_c  = '0;
            end
        endcase
    end
endmodule

// File: rtl/alu_shift_issue.sv
// Two-stage issue/retire wrapper around an external combinational shift ALU:
// S1 drives the ALU operands, S2 captures the result for the downstream consumer.
module alu_shift_issue
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_shift_issue_if.slave  bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);
    logic              s1_valid;
    logic              s1_err;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_valid;
    logic              s2_err;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_result;

    logic              s1_adv;
    logic              s2_adv;
    logic [DATA_W-1:0] norm_b;
    logic [OPC_W-1:0]  norm_op;
    logic              norm_err;

    alu_shift_amt_norm u_norm (
        .opcode    (bus.in_opcode),
        .raw_b     (bus.in_b),
        .norm_b_c  (norm_b),
        .norm_op_c (norm_op),
        .err_c     (norm_err)
    );

    // Backpressure ripples from the output register back to the request port.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv && !rst;

    // S1: issue register feeding the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s1_tag     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= OP_NOP;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_err     <= norm_err;
                s1_tag     <= bus.in_tag;
                alu_a      <= bus.in_a;
                alu_b      <= norm_b;
                alu_opcode <= norm_op;
            end
        end
    end

    // S2: result register; the ALU output reflects the current S1 contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_err    <= 1'b0;
            s2_tag    <= '0;
            s2_result <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_err    <= s1_err;
                s2_tag    <= s1_tag;
                s2_result <= s1_err ? '0 : alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (s2_valid && bus.out_ready) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_tag    = s2_tag;
    assign bus.out_err    = s2_err;
    assign busy           = s1_valid || s2_valid;
endmodule

// File: tb/tb_alu_shift_issue.sv
// Directed + random bench for alu_shift_issue with a behavioural shift ALU and
// a queue scoreboard of expected results.
module tb_alu_shift_issue;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [3:0]  tag;
    } stim_t;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        busy;
    logic [15:0] retired;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    sent_since_rst = 0;
    stim_t stim_q[$];
    exp_t  exp_q[$];

    alu_shift_issue_if #(.TAG_W(4)) bus ();

    alu_shift_issue #(.TAG_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Behavioural shift ALU seen by the DUT; illegal opcodes yield junk.
    always_comb begin
        case (alu_opcode)
            4'h6: alu_result = alu_a << alu_b;
            4'h7: alu_result = 16'($signed(alu_a) >>> alu_b);
            4'h8: alu_result = 16'((alu_a << alu_b[3:0]) | (alu_a >> (5'd16 - {1'b0, alu_b[3:0]})));
            4'h9: alu_result = 16'((alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - {1'b0, alu_b[3:0]})));
            default: alu_result = 16'hDEAD;
        endcase
    end

    function automatic exp_t ref_model(input stim_t s);
        exp_t        r;
        int          n;
        logic [31:0] wide;
        r.tag = s.tag;
        r.err = 1'b0;
        r.res = 16'h0;
        n     = int'(s.b[3:0]);
        wide  = {16'h0, s.a};
        case (s.op)
            4'h6: r.res = (s.b >= 16'd16) ? 16'h0 : 16'(wide << n);
            4'h7: r.res = (s.b >= 16'd16) ? {16{s.a[15]}} : 16'($signed(s.a) >>> n);
            4'h8: r.res = (n == 0) ? s.a : 16'((wide << n) | (wide >> (16 - n)));
            4'h9: r.res = (n == 0) ? s.a : 16'((wide >> n) | (wide << (16 - n)));
            default: begin
                r.err = 1'b1;
                r.res = 16'h0;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op, input logic [3:0] tag);
        stim_t s;
        s.a = a; s.b = b; s.op = op; s.tag = tag;
        stim_q.push_back(s);
    endtask

    // One clock: present the head stimulus, score handshakes seen at the edge.
    task automatic cycle();
        stim_t s;
        exp_t  e;
        logic  acc;
        logic  ret;
        s = '0;
        if (stim_q.size() != 0) begin
            s             = stim_q[0];
            bus.in_valid  = 1'b1;
            bus.in_a      = s.a;
            bus.in_b      = s.b;
            bus.in_opcode = s.op;
            bus.in_tag    = s.tag;
        end else begin
            bus.in_valid  = 1'b0;
        end
        #1;
        acc = bus.in_valid && bus.in_ready;
        ret = bus.out_valid && bus.out_ready;
        if (ret) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result", 32'(bus.out_result), 32'(e.res));
                check("tag", 32'(bus.out_tag), 32'(e.tag));
                check("err", 32'(bus.out_err), 32'(e.err));
            end
        end
        if (acc) begin
            exp_q.push_back(ref_model(s));
            sent_since_rst++;
            void'(stim_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && cycles < budget) begin
            cycle();
            cycles++;
        end
        check("drain_done", 32'(stim_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        int    cyc;
        stim_t s;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.in_opcode = 4'h6;
        bus.in_tag    = 4'h0;
        bus.out_ready = 1'b1;

        // Reset: in_ready held low, state cleared.
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_op", 32'(alu_opcode), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_in_ready_rel", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Single op and two-cycle latency.
        push(16'h8001, 16'd1, 4'h6, 4'd3);
        cycle();
        check("lat_n1_valid", 32'(bus.out_valid), 32'd0);
        cycle();
        check("lat_n2_valid", 32'(bus.out_valid), 32'd1);
        check("single_result", 32'(bus.out_result), 32'h0002);
        cycle();
        check("single_retired", 32'(retired), 32'd1);

        // Amount normalisation.
        push(16'h8000, 16'd40, 4'h7, 4'd4);
        push(16'h8001, 16'd17, 4'h8, 4'd5);
        push(16'h1234, 16'd16, 4'h9, 4'd6);
        cycle();
        check("norm_sar_alu_b", 32'(alu_b), 32'd16);
        cycle();
        check("norm_rol_alu_b", 32'(alu_b), 32'd1);
        drain(20, cyc);

        // Illegal opcode followed by a legal op.
        push(16'hFFFF, 16'd2, 4'h3, 4'd7);
        push(16'h00F0, 16'd4, 4'h9, 4'd8);
        cycle();
        check("illegal_alu_op", 32'(alu_opcode), 32'd0);
        drain(20, cyc);

        // Backpressure: 4 ops, downstream stalled for 5 cycles.
        bus.out_ready = 1'b0;
        push(16'h1111, 16'd1, 4'h6, 4'hA);
        push(16'h2222, 16'd2, 4'h8, 4'hB);
        push(16'h8888, 16'd3, 4'h7, 4'hC);
        push(16'h4321, 16'd4, 4'h9, 4'hD);
        for (int i = 0; i < 5; i++) cycle();
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_accepts", 32'(stim_q.size()), 32'd2);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_out_tag", 32'(bus.out_tag), 32'hA);
        check("bp_out_result", 32'(bus.out_result), 32'h2222);
        check("bp_busy", 32'(busy), 32'd1);
        bus.out_ready = 1'b1;
        drain(20, cyc);
        check("bp_retired", 32'(retired), 32'(sent_since_rst));

        // Full-throughput random stream.
        for (int i = 0; i < 100; i++) begin
            s.a = 16'($urandom);
            s.b = 16'($urandom_range(0, 40));
            case ($urandom_range(0, 5))
                0: s.op = 4'h6;
                1: s.op = 4'h7;
                2: s.op = 4'h8;
                3: s.op = 4'h9;
                4: s.op = 4'h3;
                default: s.op = 4'hF;
            endcase
            s.tag = 4'(i);
            stim_q.push_back(s);
        end
        drain(300, cyc);
        check("stream_cycles", 32'(cyc), 32'd102);
        check("stream_retired", 32'(retired), 32'(sent_since_rst));

        // Reset with both stages occupied.
        bus.out_ready = 1'b0;
        push(16'h0F0F, 16'd1, 4'h6, 4'h1);
        push(16'hF0F0, 16'd2, 4'h7, 4'h2);
        push(16'hAAAA, 16'd3, 4'h8, 4'h3);
        for (int i = 0; i < 3; i++) cycle();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_retired", 32'(retired), 32'd0);
        stim_q.delete();
        exp_q.delete();
        sent_since_rst = 0;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_rst_no_out", 32'(bus.out_valid), 32'd0);
        end
        push(16'h0001, 16'd15, 4'h6, 4'h9);
        drain(20, cyc);
        check("post_rst_retired", 32'(retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
